pipe_regs: RTL

Bank of Y86-64 pipeline registers (F predPC, D, E, M, W) plus the condition-code register. It sits between the stage datapaths and the pipeline control unit, consuming that unit's per-stage stall/bubble/SetCC decisions. Each register loads its stage's next value, holds it, or injects a bubble, every clock. All outputs are flops; no combinational input-to-output path exists.

---
 rtl/pipe_regs_pkg.sv | 69 ++++++
 rtl/pipe_regs_if.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 27 ++
 rtl/pipe_regs.sv | 83 ++++++++
 4 files changed

// File: rtl/pipe_regs_pkg.sv
// Y86-64 pipeline register types, encodings and per-stage bubble constants.
// Shared by the register bank, its interface and the bench.
package y86_pipe_pkg;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_ADR = 4'b0100;
  localparam logic [3:0] STAT_INS = 4'b0010;
  localparam logic [3:0] STAT_HLT = 4'b0001;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_c;
    logic [63:0] val_p;
  } d_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } e_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  // A bubble is a nop that is architecturally healthy and writes no register.
  localparam d_reg_t D_BUBBLE = '{stat: STAT_AOK, icode: INOP, ifun: 4'h0,
                                  ra: RNONE, rb: RNONE, val_c: 64'h0, val_p: 64'h0};
  localparam e_reg_t E_BUBBLE = '{stat: STAT_AOK, icode: INOP, ifun: 4'h0,
                                  val_c: 64'h0, val_a: 64'h0, val_b: 64'h0,
                                  dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE};
  localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: INOP, cnd: 1'b0,
                                  val_e: 64'h0, val_a: 64'h0, dst_e: RNONE, dst_m: RNONE};
  localparam w_reg_t W_BUBBLE = '{stat: STAT_AOK, icode: INOP, val_e: 64'h0,
                                  val_m: 64'h0, dst_e: RNONE, dst_m: RNONE};

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/pipe_regs_if.sv
// Bundle between stage datapaths/pipeline control and the register bank.
// master = datapath/control side, slave = pipe_regs.
interface pipe_regs_if
  import y86_pipe_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             f_stall;
  logic             d_stall;
  logic             d_bubble;
  logic             e_bubble;
  logic             m_bubble;
  logic             w_stall;
  logic             set_cc;
  logic             cc_we;
  logic [2:0]       cc_next;
  logic [63:0]      f_pred_next;
  d_reg_t           d_next;
  e_reg_t           e_next;
  m_reg_t           m_next;
  w_reg_t           w_next;
  logic [63:0]      f_pred_pc;
  d_reg_t           d_q;
  e_reg_t           e_q;
  m_reg_t           m_q;
  w_reg_t           w_q;
  logic [2:0]       cc_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
           set_cc, cc_we, cc_next, f_pred_next, d_next, e_next, m_next, w_next,
    input  f_pred_pc, d_q, e_q, m_q, w_q, cc_q, stall_cnt, bubble_cnt, cycle_cnt
  );

  modport slave (
    input  f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall,
           set_cc, cc_we, cc_next, f_pred_next, d_next, e_next, m_next, w_next,
    output f_pred_pc, d_q, e_q, m_q, w_q, cc_q, stall_cnt, bubble_cnt, cycle_cnt
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline register: 1-cycle load, stall holds (wins over bubble), bubble loads BUBBLE_VAL.
// Reset also loads BUBBLE_VAL, so predPC passes RESET_PC here with bubble tied low.
module pipe_stage_reg #(
  parameter int           W          = 64,
  parameter logic [W-1:0] BUBBLE_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BUBBLE_VAL;
    end else if (stall) begin
      q <= q;
    end else if (bubble) begin
      q <= BUBBLE_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_regs.sv
// Y86-64 F/D/E/M/W pipeline registers + CC; 1-cycle load, stall > bubble > load, all outputs flopped.
// Optional saturating perf counters under `PIPE_REGS_PERF_EN; otherwise the counter ports read 0.
module pipe_regs
  import y86_pipe_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_regs_if.slave bus
);

  pipe_stage_reg #(.W(64), .BUBBLE_VAL(RESET_PC)) u_f_reg (
    .clk(clk), .rst_n(rst_n), .stall(bus.f_stall), .bubble(1'b0),
    .d(bus.f_pred_next), .q(bus.f_pred_pc)
  );

  pipe_stage_reg #(.W($bits(d_reg_t)), .BUBBLE_VAL(D_BUBBLE)) u_d_reg (
    .clk(clk), .rst_n(rst_n), .stall(bus.d_stall), .bubble(bus.d_bubble),
    .d(bus.d_next), .q(bus.d_q)
  );

  pipe_stage_reg #(.W($bits(e_reg_t)), .BUBBLE_VAL(E_BUBBLE)) u_e_reg (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(bus.e_bubble),
    .d(bus.e_next), .q(bus.e_q)
  );

  pipe_stage_reg #(.W($bits(m_reg_t)), .BUBBLE_VAL(M_BUBBLE)) u_m_reg (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(bus.m_bubble),
    .d(bus.m_next), .q(bus.m_q)
  );

  pipe_stage_reg #(.W($bits(w_reg_t)), .BUBBLE_VAL(W_BUBBLE)) u_w_reg (
    .clk(clk), .rst_n(rst_n), .stall(bus.w_stall), .bubble(1'b0),
    .d(bus.w_next), .q(bus.w_q)
  );

  // CC updates only when execute has an OPq and control has not squashed it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cc_q <= CC_RESET;
    end else if (bus.cc_we && bus.set_cc) begin
      bus.cc_q <= bus.cc_next;
    end
  end

`ifdef PIPE_REGS_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [CNT_W-1:0] cycle_cnt_r;

  // Counters saturate at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r  <= '0;
      bubble_cnt_r <= '0;
      cycle_cnt_r  <= '0;
    end else begin
      if (cycle_cnt_r != '1) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end
      if (bus.f_stall && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (bus.e_bubble && (bubble_cnt_r != '1)) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end
    end
  end

  assign bus.stall_cnt  = stall_cnt_r;
  assign bus.bubble_cnt = bubble_cnt_r;
  assign bus.cycle_cnt  = cycle_cnt_r;
`else
  assign bus.stall_cnt  = '0;
  assign bus.bubble_cnt = '0;
  assign bus.cycle_cnt  = '0;
`endif

endmodule
